// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcode/funct
// constants, ALUctl encodings and datapath select encodings.
package mc_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_BEQ, S_JUMP, S_IMM_EX, S_IMM_WB
  } state_e;

  // Which ALU operation family the current state needs
  typedef enum logic [2:0] {CLS_NONE, CLS_ADD, CLS_RTYPE, CLS_BEQ, CLS_IMM} alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
  } ctl_t;

  function automatic alu_cls_e state_alu_cls(input state_e s);
    case (s)
      S_FETCH, S_DECODE, S_MEMADR: return CLS_ADD;
      S_RTYPE_EX:                  return CLS_RTYPE;
      S_BEQ:                       return CLS_BEQ;
      S_IMM_EX:                    return CLS_IMM;
      default:                     return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flag in, selects and
// strobes out. master = control unit, slave = datapath.
interface mc_control_unit_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic [3:0] ALUctl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       IllegalOp;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output ALUctl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, IllegalOp
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  ALUctl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, IllegalOp
  );
endinterface

// File: rtl/mc_control_unit_alu_ctl_decode.sv
// Combinational ALU control decode: maps the state's ALU class plus Op/Funct to
// ALUctl, and flags whether Funct is a supported R-type function.
module alu_ctl_decode
  import mc_control_unit_pkg::*;
(
  input  alu_cls_e   i_cls,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_aluctl,
  output logic       o_funct_legal
);

  logic [3:0] w_funct_ctl;
  logic [3:0] w_imm_ctl;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_funct_ctl   = ALU_AND;
    o_funct_legal = 1'b1;
    case (i_funct)
      FN_ADD:  w_funct_ctl = ALU_ADD;
      FN_SUB:  w_funct_ctl = ALU_SUB;
      FN_AND:  w_funct_ctl = ALU_AND;
      FN_OR:   w_funct_ctl = ALU_OR;
      FN_SLT:  w_funct_ctl = ALU_SLT;
      default: o_funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_imm_ctl = ALU_AND;
    case (i_op)
      OP_ADDI: w_imm_ctl = ALU_ADD;
      OP_SLTI: w_imm_ctl = ALU_SLT;
      OP_ANDI: w_imm_ctl = ALU_AND;
      OP_ORI:  w_imm_ctl = ALU_OR;
      default: w_imm_ctl = ALU_AND;
    endcase
  end

  always_comb begin
    o_aluctl = ALU_AND;
    case (i_cls)
      CLS_ADD:   o_aluctl = ALU_ADD;
      CLS_RTYPE: o_aluctl = w_funct_ctl;
      CLS_BEQ:   o_aluctl = ALU_SUB;
      CLS_IMM:   o_aluctl = w_imm_ctl;
      default:   o_aluctl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory-ready stalls and illegal-op detection.
// Define MC_CTL_IMM_EN to decode addi/slti/andi/ori (andi/ori use sign-extended imm).
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  mc_control_unit_if.master   bus
);

  state_e     r_state;
  state_e     w_next;
  alu_cls_e   w_cls;
  logic [3:0] w_aluctl;
  logic       w_funct_legal;
  ctl_t       w_ctl;

  assign w_cls = state_alu_cls(r_state);

  alu_ctl_decode u_alu_ctl_decode (
    .i_cls         (w_cls),
    .i_op          (bus.Op),
    .i_funct       (bus.Funct),
    .o_aluctl      (w_aluctl),
    .o_funct_legal (w_funct_legal)
  );

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_ctl         = '0;
    w_ctl.alu_ctl = w_aluctl;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.pc_source = PCSRC_ALU;
        w_ctl.ir_write  = bus.MemReady;
        w_ctl.pc_en     = bus.MemReady;
        if (bus.MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ctl.alu_src_b = SRCB_IMM_SH;
        case (bus.Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          OP_RTYPE: begin
            if (w_funct_legal) w_next = S_RTYPE_EX;
            else begin
              w_ctl.illegal_op = 1'b1;
              w_next           = S_FETCH;
            end
          end
`ifdef MC_CTL_IMM_EN
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_IMM_EX;
`endif
          default: begin
            w_ctl.illegal_op = 1'b1;
            w_next           = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_next          = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_ctl.i_or_d   = 1'b1;
        w_ctl.mem_read = 1'b1;
        if (bus.MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.reg_write  = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEMWR: begin
        w_ctl.i_or_d    = 1'b1;
        w_ctl.mem_write = 1'b1;
        if (bus.MemReady) w_next = S_FETCH;
      end
      S_RTYPE_EX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_B;
        w_next          = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        w_ctl.reg_dst   = 1'b1;
        w_ctl.reg_write = 1'b1;
        w_next          = S_FETCH;
      end
      S_BEQ: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_B;
        w_ctl.pc_source = PCSRC_ALUOUT;
        w_ctl.pc_en     = bus.Zero;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_ctl.pc_source = PCSRC_JUMP;
        w_ctl.pc_en     = 1'b1;
        w_next          = S_FETCH;
      end
`ifdef MC_CTL_IMM_EN
      S_IMM_EX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_next          = S_IMM_WB;
      end
      S_IMM_WB: begin
        w_ctl.reg_write = 1'b1;
        w_next          = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset forces every output low at once so an aborted access writes nothing.
    if (!reset_n) w_ctl = '0;
  end

  assign bus.ALUctl    = w_ctl.alu_ctl;
  assign bus.ALUSrcA   = w_ctl.alu_src_a;
  assign bus.ALUSrcB   = w_ctl.alu_src_b;
  assign bus.PCSource  = w_ctl.pc_source;
  assign bus.PCEn      = w_ctl.pc_en;
  assign bus.IorD      = w_ctl.i_or_d;
  assign bus.MemRead   = w_ctl.mem_read;
  assign bus.MemWrite  = w_ctl.mem_write;
  assign bus.IRWrite   = w_ctl.ir_write;
  assign bus.RegDst    = w_ctl.reg_dst;
  assign bus.MemtoReg  = w_ctl.mem_to_reg;
  assign bus.RegWrite  = w_ctl.reg_write;
  assign bus.IllegalOp = w_ctl.illegal_op;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: each step compares the full output vector
// against a hand-written per-state signature.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Field order: ALUctl | ALUSrcA | ALUSrcB | PCSource | PCEn IorD MemRead MemWrite
  //              IRWrite RegDst MemtoReg RegWrite IllegalOp
  logic [17:0] obs;
  assign obs = {bus.ALUctl, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCEn, bus.IorD,
                bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.IllegalOp};

  localparam logic [17:0] ALL_ZERO   = 18'b0000_0_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] FETCH_WAIT = 18'b0010_0_01_00_0_0_1_0_0_0_0_0_0;
  localparam logic [17:0] FETCH_RDY  = 18'b0010_0_01_00_1_0_1_0_1_0_0_0_0;
  localparam logic [17:0] DECODE     = 18'b0010_0_11_00_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] DECODE_ILL = 18'b0010_0_11_00_0_0_0_0_0_0_0_0_1;
  localparam logic [17:0] MEMADR     = 18'b0010_1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] MEMRD      = 18'b0000_0_00_00_0_1_1_0_0_0_0_0_0;
  localparam logic [17:0] MEMWB      = 18'b0000_0_00_00_0_0_0_0_0_0_1_1_0;
  localparam logic [17:0] MEMWR      = 18'b0000_0_00_00_0_1_0_1_0_0_0_0_0;
  localparam logic [17:0] RTYPE_SUB  = 18'b0110_1_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] RTYPE_WB   = 18'b0000_0_00_00_0_0_0_0_0_1_0_1_0;
  localparam logic [17:0] BEQ_TAKEN  = 18'b0110_1_00_01_1_0_0_0_0_0_0_0_0;
  localparam logic [17:0] BEQ_NOT    = 18'b0110_1_00_01_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] JUMP       = 18'b0000_0_00_10_1_0_0_0_0_0_0_0_0;
  localparam logic [17:0] IMM_EX_ADD = 18'b0010_1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [17:0] IMM_WB     = 18'b0000_0_00_00_0_0_0_0_0_0_0_1_0;

  task automatic check(input string tag, input logic [17:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.Op       = 6'b100011;
    bus.Funct    = 6'b000000;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    check("reset_idle", ALL_ZERO);
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
    check("post_reset_fetch", FETCH_RDY);

    // lw aborted by reset while stalled in MEMRD
    cyc();                      check("lw_decode", DECODE);
    cyc();                      check("lw_memadr", MEMADR);
    bus.MemReady = 1'b0;
    cyc();                      check("lw_memrd_stall", MEMRD);
    reset_n = 1'b0;  #1;        check("reset_mid_memrd", ALL_ZERO);
    cyc();                      check("reset_held", ALL_ZERO);
    reset_n = 1'b1;  #1;        check("release_fetch", FETCH_WAIT);

    // R-type sub, 4 cycles
    bus.MemReady = 1'b1;
    bus.Op = 6'b000000;  bus.Funct = 6'b100010;
    #1;                         check("sub_fetch", FETCH_RDY);
    cyc();                      check("sub_decode", DECODE);
    cyc();                      check("sub_ex", RTYPE_SUB);
    cyc();                      check("sub_wb", RTYPE_WB);
    cyc();                      check("sub_done_fetch", FETCH_RDY);

    // beq taken then not taken, 3 cycles each
    bus.Op = 6'b000100;  bus.Zero = 1'b1;
    #1;
    cyc();                      check("beq1_decode", DECODE);
    cyc();                      check("beq1_taken", BEQ_TAKEN);
    cyc();                      check("beq1_done_fetch", FETCH_RDY);
    bus.Zero = 1'b0;
    cyc();                      check("beq0_decode", DECODE);
    cyc();                      check("beq0_not_taken", BEQ_NOT);
    cyc();                      check("beq0_done_fetch", FETCH_RDY);

    // lw with 2 FETCH stalls and 3 MEMRD stalls, 10 cycles
    bus.Op = 6'b100011;  bus.MemReady = 1'b0;
    #1;                         check("lws_fetch_w0", FETCH_WAIT);
    cyc();                      check("lws_fetch_w1", FETCH_WAIT);
    cyc();  bus.MemReady = 1'b1;
    #1;                         check("lws_fetch_rdy", FETCH_RDY);
    cyc();                      check("lws_decode", DECODE);
    cyc();                      check("lws_memadr", MEMADR);
    bus.MemReady = 1'b0;
    cyc();                      check("lws_memrd_w0", MEMRD);
    cyc();                      check("lws_memrd_w1", MEMRD);
    cyc();                      check("lws_memrd_w2", MEMRD);
    cyc();  bus.MemReady = 1'b1;
    #1;                         check("lws_memrd_rdy", MEMRD);
    cyc();                      check("lws_memwb", MEMWB);
    cyc();                      check("lws_done_fetch", FETCH_RDY);

    // sw with one MEMWR stall
    bus.Op = 6'b101011;
    #1;
    cyc();                      check("sw_decode", DECODE);
    cyc();                      check("sw_memadr", MEMADR);
    bus.MemReady = 1'b0;
    cyc();                      check("sw_memwr_stall", MEMWR);
    cyc();  bus.MemReady = 1'b1;
    #1;                         check("sw_memwr_rdy", MEMWR);
    cyc();                      check("sw_done_fetch", FETCH_RDY);

    // jump
    bus.Op = 6'b000010;
    #1;
    cyc();                      check("j_decode", DECODE);
    cyc();                      check("j_jump", JUMP);
    cyc();                      check("j_done_fetch", FETCH_RDY);

    // illegal opcode and illegal funct
    bus.Op = 6'b111111;
    #1;
    cyc();                      check("ill_op_decode", DECODE_ILL);
    cyc();                      check("ill_op_fetch", FETCH_RDY);
    bus.Op = 6'b000000;  bus.Funct = 6'b000111;
    #1;
    cyc();                      check("ill_fn_decode", DECODE_ILL);
    cyc();                      check("ill_fn_fetch", FETCH_RDY);

    // addi: decoded only when the immediate option is built
    bus.Op = 6'b001000;  bus.Funct = 6'b000000;
    #1;
`ifdef MC_CTL_IMM_EN
    cyc();                      check("addi_decode", DECODE);
    cyc();                      check("addi_ex", IMM_EX_ADD);
    cyc();                      check("addi_wb", IMM_WB);
    cyc();                      check("addi_done_fetch", FETCH_RDY);
`else
    cyc();                      check("addi_illegal", DECODE_ILL);
    cyc();                      check("addi_fetch", FETCH_RDY);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle MIPS control FSM that drives the datapath ALU's 4-bit ALUctl and samples its Zero flag. It sequences fetch, decode, execute, memory and writeback, and drives mux selects and write strobes for PC, IR, memory and register file. It stalls on a memory-ready handshake and flags illegal instructions.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- Op  in  6  IR[31:26] opcode
- Funct  in  6  IR[5:0] function field
- Zero  in  1  ALU zero flag, same cycle as ALUctl
- MemReady  in  1  memory access completes this cycle
- ALUctl  out  4  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- PCSource  out  2  00 = ALU result, 01 = ALUOut reg, 10 = jump target
- PCEn  out  1  PC load enable
- IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite  out  1 each  datapath strobes/selects
- IllegalOp  out  1  one-cycle pulse on undecodable instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ, JUMP, IMM_EX, IMM_WB.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctl=ADD, PCSource=00. IRWrite and PCEn assert only in the cycle MemReady=1, then go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUctl=ADD (branch target into ALUOut).
  - lw(100011)/sw(101011) -> MEMADR
  - R-type(000000) with legal Funct -> RTYPE_EX
  - beq(000100) -> BEQ
  - j(000010) -> JUMP
  - Any other opcode, or R-type with unknown Funct: IllegalOp=1 this cycle, -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUctl=ADD. lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD=1, MemRead=1. Holds until MemReady, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, -> FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until MemReady, then -> FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00. ALUctl from Funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. -> RTYPE_WB.
- RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1, -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUctl=SUB, PCSource=01, PCEn=Zero, -> FETCH.
- JUMP: PCSource=10, PCEn=1, -> FETCH.
- Unlisted outputs are 0 in every state. Strobes are decoded from the current state only, except IRWrite/PCEn in FETCH (gated by MemReady) and PCEn in BEQ (gated by Zero).

## Timing
- Reset: state=FETCH. While reset_n=0, every output is forced to 0. FETCH decode begins in the first cycle after release.
- Reset asserted mid-instruction aborts it immediately. No partial writes occur after reset assertion.
- Cycles per instruction with MemReady tied 1: R-type 4, lw 5, sw 4, beq 3, j 3, immediate 4. Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- MemRead/MemWrite stay asserted and addresses stay stable for the whole stall.
- Zero is sampled combinationally in BEQ only. The ALU is combinational, so ALUctl and Zero settle within the same cycle.
- IllegalOp is never asserted outside DECODE.

## Configuration
- MC_CTL_IMM_EN defined: addi(001000) ADD, slti(001010) SLT, andi(001100) AND, ori(001101) OR are decoded.
  - DECODE -> IMM_EX: ALUSrcA=1, ALUSrcB=10, ALUctl per opcode.
  - IMM_EX -> IMM_WB: RegDst=0, MemtoReg=0, RegWrite=1, -> FETCH.
  - andi/ori use sign-extended immediate (datapath limitation, documented).
- Undefined: IMM_EX/IMM_WB are not built, and these four opcodes raise IllegalOp in DECODE.

## Structure
- Shared package: state enum, opcode constants, Funct constants, ALUctl encodings, ALUSrcB/PCSource select encodings. These are shared with the datapath and the ALU bench.
- One combinational sub-module alu_ctl_decode maps (state class, Op, Funct) to ALUctl plus a funct_legal flag. The FSM instantiates it once.

## Test plan
- Reset mid-lw in MEMRD -> all outputs 0 during reset; first post-release cycle is FETCH with MemRead=1, ALUctl=0010.
- R-type sub (Funct 100010), MemReady=1 -> RTYPE_EX ALUctl=0110, RTYPE_WB RegWrite=1 RegDst=1; 4 cycles total.
- beq with Zero=1 then Zero=0 -> PCEn=1 PCSource=01 in the first case, PCEn=0 in the second; 3 cycles each.
- lw with MemReady low 2 cycles in FETCH and 3 in MEMRD -> IRWrite/PCEn single pulse on the ready cycle; MemRead held; total 10 cycles.
- Op=111111, and R-type Funct 000111 -> IllegalOp one-cycle pulse in DECODE, next state FETCH, no RegWrite/MemWrite.
- addi (001000) with and without MC_CTL_IMM_EN -> IMM_EX ALUctl=0010 then RegWrite=1 RegDst=0; without the macro, IllegalOp=1.
